// File: rtl/sc_cc_sequencer_pkg.sv
// Shared encodings for the SPARC-subset control sequencer:
// FSM states, instruction field codes, condition codes and PC select codes.
package sc_cc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_MEM,
        ST_BRANCH,
        ST_RETIRE
    } state_e;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ALU    = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;

    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_CALL   = 2'b10;

    // Low three bits of the Bicc cond field; bit 3 inverts the sense.
    localparam logic [2:0] CC_NEVER = 3'd0;
    localparam logic [2:0] CC_E     = 3'd1;
    localparam logic [2:0] CC_LE    = 3'd2;
    localparam logic [2:0] CC_L     = 3'd3;
    localparam logic [2:0] CC_LEU   = 3'd4;
    localparam logic [2:0] CC_CS    = 3'd5;
    localparam logic [2:0] CC_NEG   = 3'd6;
    localparam logic [2:0] CC_VS    = 3'd7;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/sc_cc_sequencer_cond_eval.sv
// Bicc condition evaluator: (cond, {N,Z,V,C}) -> taken.
// Purely combinational so later pipeline stages can reuse it.
module sc_cc_sequencer_cond_eval
    import sc_cc_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n;
    logic z;
    logic v;
    logic c;
    logic base;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    always_comb begin
        base = 1'b0;
        unique case (cond[2:0])
            CC_NEVER: base = 1'b0;
            CC_E:     base = z;
            CC_LE:    base = z | (n ^ v);
            CC_L:     base = n ^ v;
            CC_LEU:   base = c | z;
            CC_CS:    base = c;
            CC_NEG:   base = n;
            CC_VS:    base = v;
            default:  base = 1'b0;
        endcase
    end

    assign taken = cond[3] ^ base;

endmodule

// File: rtl/sc_cc_sequencer.sv
// Multicycle control sequencer for the SPARC-subset datapath.
// Outputs are a Moore decode of the state and the latched instruction fields.
module sc_cc_sequencer
    import sc_cc_sequencer_pkg::*;
#(
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_INSTR         = 32,
    parameter int MEM_TIMEOUT             = 15,
    parameter int TIMEOUT_WIDTH           = 4
) (
    input  logic                               SC_CcSeq_CLOCK_50,
    input  logic                               SC_CcSeq_RESET_InHigh,
    input  logic [DATAWIDTH_INSTR-1:0]         SC_CcSeq_Instr_In,
    input  logic                               SC_CcSeq_InstrValid_In,
    output logic                               SC_CcSeq_InstrReady_Out,
    input  logic [3:0]                         SC_CcSeq_Psr_In,
    input  logic                               SC_CcSeq_MemAck_In,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] SC_CcSeq_AluSel_Out,
    output logic                               SC_CcSeq_PsrWrite_OutLow,
    output logic                               SC_CcSeq_RegWrite_OutLow,
    output logic                               SC_CcSeq_MemReq_Out,
    output logic                               SC_CcSeq_MemWrite_Out,
    output logic                               SC_CcSeq_PcLoad_OutLow,
    output logic [1:0]                         SC_CcSeq_PcSel_Out,
    output logic                               SC_CcSeq_Illegal_Out,
    output logic                               SC_CcSeq_Timeout_Out
);

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
        TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);

    state_e                   state;
    logic [1:0]               op_q;
    logic [3:0]               cond_q;
    logic [5:0]               op3_q;
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic [1:0]               pc_sel;
    logic                     illegal;
    logic                     timeout;

    logic [2:0] op2;
    logic       is_alu;
    logic       is_bicc;
    logic       is_mem;
    logic       is_call;
    logic       is_store;
    logic       taken;
    logic       unused_instr_bits;

    // Only op, cond and op3 (op2 is its top three bits) steer the sequencer.
    assign unused_instr_bits = ^{SC_CcSeq_Instr_In[29],
                                 SC_CcSeq_Instr_In[18:0]};

    assign op2      = op3_q[5:3];
    assign is_alu   = (op_q == OP_ALU) && !op3_q[5];
    assign is_bicc  = (op_q == OP_BRANCH) && (op2 == OP2_BICC);
    assign is_mem   = (op_q == OP_MEM);
    assign is_call  = (op_q == OP_CALL);
    assign is_store = op3_q[2];

    sc_cc_sequencer_cond_eval u_cond_eval (
        .cond  (cond_q),
        .flags (SC_CcSeq_Psr_In),
        .taken (taken)
    );

    always_ff @(posedge SC_CcSeq_CLOCK_50 or posedge SC_CcSeq_RESET_InHigh) begin
        if (SC_CcSeq_RESET_InHigh) begin
            state   <= ST_FETCH;
            op_q    <= '0;
            cond_q  <= '0;
            op3_q   <= '0;
            cnt     <= '0;
            pc_sel  <= PCSEL_SEQ;
            illegal <= 1'b0;
            timeout <= 1'b0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (SC_CcSeq_InstrValid_In) begin
                        op_q   <= SC_CcSeq_Instr_In[31:30];
                        cond_q <= SC_CcSeq_Instr_In[28:25];
                        op3_q  <= SC_CcSeq_Instr_In[24:19];
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    unique case (1'b1)
                        is_alu:  state <= ST_EXEC;
                        is_bicc: state <= ST_BRANCH;
                        is_mem: begin
                            cnt   <= '0;
                            state <= ST_MEM;
                        end
                        is_call: begin
                            pc_sel <= PCSEL_CALL;
                            state  <= ST_RETIRE;
                        end
                        default: begin
                            illegal <= 1'b1;
                            pc_sel  <= PCSEL_SEQ;
                            state   <= ST_RETIRE;
                        end
                    endcase
                end
                ST_EXEC: state <= ST_WB;
                ST_WB:   state <= ST_RETIRE;
                ST_MEM: begin
                    // An ack on the final wait cycle still wins over the abort.
                    if (SC_CcSeq_MemAck_In) begin
                        state <= is_store ? ST_RETIRE : ST_WB;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        state   <= ST_RETIRE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BRANCH: begin
                    pc_sel <= taken ? PCSEL_BRANCH : PCSEL_SEQ;
                    state  <= ST_RETIRE;
                end
                ST_RETIRE: begin
                    pc_sel <= PCSEL_SEQ;
                    state  <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign SC_CcSeq_InstrReady_Out  = (state == ST_FETCH) &&
                                      !SC_CcSeq_RESET_InHigh;
    assign SC_CcSeq_AluSel_Out      = (state == ST_EXEC) ? op3_q[3:0] : '0;
    assign SC_CcSeq_RegWrite_OutLow = !(state == ST_WB);
    // Loads also pass through WB, but only cc-variant ALU ops touch the PSR.
    assign SC_CcSeq_PsrWrite_OutLow = !((state == ST_WB) &&
                                        (op_q == OP_ALU) && op3_q[4]);
    assign SC_CcSeq_MemReq_Out      = (state == ST_MEM);
    assign SC_CcSeq_MemWrite_Out    = (state == ST_MEM) && is_store;
    assign SC_CcSeq_PcLoad_OutLow   = !(state == ST_RETIRE);
    assign SC_CcSeq_PcSel_Out       = pc_sel;
    assign SC_CcSeq_Illegal_Out     = illegal;
    assign SC_CcSeq_Timeout_Out     = timeout;

endmodule

// File: tb/tb_sc_cc_sequencer.sv
// Self-checking bench for sc_cc_sequencer: directed steps plus random
// instructions compared against a per-instruction outcome model.
module tb_sc_cc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        valid;
    logic        ready;
    logic [3:0]  psr;
    logic        ack;
    logic [3:0]  alu_sel;
    logic        psr_wr_n;
    logic        reg_wr_n;
    logic        mem_req;
    logic        mem_wr;
    logic        pc_load_n;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    logic exp_illegal = 1'b0;
    logic exp_timeout = 1'b0;

    typedef struct {
        int         retire;
        int         regwr;
        int         psrwr;
        int         memcyc;
        logic       memwr;
        logic [3:0] alusel;
        logic [1:0] pcsel;
        logic       illegal;
        logic       timeout;
    } exp_t;

    sc_cc_sequencer dut (
        .SC_CcSeq_CLOCK_50        (clk),
        .SC_CcSeq_RESET_InHigh    (rst),
        .SC_CcSeq_Instr_In        (instr),
        .SC_CcSeq_InstrValid_In   (valid),
        .SC_CcSeq_InstrReady_Out  (ready),
        .SC_CcSeq_Psr_In          (psr),
        .SC_CcSeq_MemAck_In       (ack),
        .SC_CcSeq_AluSel_Out      (alu_sel),
        .SC_CcSeq_PsrWrite_OutLow (psr_wr_n),
        .SC_CcSeq_RegWrite_OutLow (reg_wr_n),
        .SC_CcSeq_MemReq_Out      (mem_req),
        .SC_CcSeq_MemWrite_Out    (mem_wr),
        .SC_CcSeq_PcLoad_OutLow   (pc_load_n),
        .SC_CcSeq_PcSel_Out       (pc_sel),
        .SC_CcSeq_Illegal_Out     (illegal),
        .SC_CcSeq_Timeout_Out     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c,
                                      input logic [3:0] f);
        logic n, z, v, cy;
        {n, z, v, cy} = f;
        case (c)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b1001: return !z;
            4'b0001: return z;
            4'b1010: return !(z | (n ^ v));
            4'b0010: return z | (n ^ v);
            4'b1011: return !(n ^ v);
            4'b0011: return n ^ v;
            4'b1100: return !(cy | z);
            4'b0100: return cy | z;
            4'b1101: return !cy;
            4'b0101: return cy;
            4'b1110: return !n;
            4'b0110: return n;
            4'b1111: return !v;
            4'b0111: return v;
            default: return 1'b0;
        endcase
    endfunction

    // Outcome of one instruction: retire cycle (1 = cycle after handshake),
    // strobe counts, MEM occupancy and the PC select used at retire.
    function automatic exp_t model(input logic [31:0] w, input logic [3:0] f,
                                   input int ack_at);
        exp_t e;
        logic [1:0] op;
        logic [5:0] op3;
        int m;
        op  = w[31:30];
        op3 = w[24:19];
        e = '{retire: 2, regwr: 0, psrwr: 0, memcyc: 0, memwr: 1'b0,
              alusel: 4'h0, pcsel: 2'b00, illegal: 1'b0, timeout: 1'b0};
        if (op == 2'b10 && !op3[5]) begin
            e.retire = 4;
            e.regwr  = 1;
            e.psrwr  = op3[4] ? 1 : 0;
            e.alusel = op3[3:0];
        end else if (op == 2'b00 && w[24:22] == 3'b010) begin
            e.retire = 3;
            e.pcsel  = cond_ref(w[28:25], f) ? 2'b01 : 2'b00;
        end else if (op == 2'b01) begin
            e.pcsel = 2'b10;
        end else if (op == 2'b11) begin
            if (ack_at >= 1 && ack_at <= 15) m = ack_at;
            else begin
                m = 15;
                e.timeout = 1'b1;
            end
            e.memcyc = m;
            e.memwr  = op3[2];
            if (!e.timeout && !op3[2]) begin
                e.regwr  = 1;
                e.retire = m + 3;
            end else begin
                e.retire = m + 2;
            end
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // Called just after a falling edge with the sequencer idle in FETCH.
    task automatic run_instr(input logic [31:0] w, input logic [3:0] f,
                             input int ack_at, input string tag);
        exp_t e;
        int retire_k, regwr_n, psrwr_n, memreq_n, pcload_n, ready_n;
        logic memwr_seen, rdy_after;
        logic [3:0] alu_or;
        logic [1:0] pcsel_r;
        e = model(w, f, ack_at);
        exp_illegal = exp_illegal | e.illegal;
        exp_timeout = exp_timeout | e.timeout;
        retire_k = -1; regwr_n = 0; psrwr_n = 0; memreq_n = 0;
        pcload_n = 0; ready_n = 0;
        memwr_seen = 1'b0; rdy_after = 1'b0;
        alu_or = 4'h0; pcsel_r = 2'b11;
        instr = w; valid = 1'b1; psr = f;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                valid = 1'b0;
                instr = $urandom;
            end
            if (!reg_wr_n) regwr_n++;
            if (!psr_wr_n) psrwr_n++;
            alu_or = alu_or | alu_sel;
            if (mem_req) begin
                memreq_n++;
                memwr_seen = mem_wr;
                ack = (memreq_n == ack_at);
            end else begin
                ack = 1'($urandom_range(0, 1));
            end
            if (retire_k > 0 && k == retire_k + 1) begin
                rdy_after = ready;
                if (!pc_load_n) pcload_n++;
                break;
            end
            if (ready) ready_n++;
            if (!pc_load_n) begin
                pcload_n++;
                if (retire_k < 0) begin
                    retire_k = k;
                    pcsel_r  = pc_sel;
                end
            end
        end
        ack = 1'b0;
        check({tag, ".retire"}, 32'(retire_k), 32'(e.retire));
        check({tag, ".pcsel"}, 32'(pcsel_r), 32'(e.pcsel));
        check({tag, ".pcload_pulses"}, 32'(pcload_n), 32'd1);
        check({tag, ".regwr"}, 32'(regwr_n), 32'(e.regwr));
        check({tag, ".psrwr"}, 32'(psrwr_n), 32'(e.psrwr));
        check({tag, ".memreq"}, 32'(memreq_n), 32'(e.memcyc));
        if (e.memcyc > 0)
            check({tag, ".memwrite"}, 32'(memwr_seen), 32'(e.memwr));
        check({tag, ".alusel"}, 32'(alu_or), 32'(e.alusel));
        check({tag, ".busy_ready"}, 32'(ready_n), 32'd0);
        check({tag, ".ready_after"}, 32'(rdy_after), 32'd1);
        check({tag, ".illegal"}, 32'(illegal), 32'(exp_illegal));
        check({tag, ".timeout"}, 32'(timeout), 32'(exp_timeout));
    endtask

    task automatic check_idle(input string tag, input logic exp_ready);
        check({tag, ".ready"}, 32'(ready), 32'(exp_ready));
        check({tag, ".psrwr_n"}, 32'(psr_wr_n), 32'd1);
        check({tag, ".regwr_n"}, 32'(reg_wr_n), 32'd1);
        check({tag, ".pcload_n"}, 32'(pc_load_n), 32'd1);
        check({tag, ".memreq"}, 32'(mem_req), 32'd0);
        check({tag, ".pcsel"}, 32'(pc_sel), 32'd0);
        check({tag, ".alusel"}, 32'(alu_sel), 32'd0);
        check({tag, ".illegal"}, 32'(illegal), 32'd0);
        check({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    function automatic logic [31:0] fmt3(input logic [1:0] op,
                                         input logic [5:0] op3);
        logic [31:0] w;
        w = $urandom;
        w[31:30] = op;
        w[24:19] = op3;
        return w;
    endfunction

    function automatic logic [31:0] bicc(input logic [3:0] c);
        logic [31:0] w;
        w = $urandom;
        w[31:30] = 2'b00;
        w[28:25] = c;
        w[24:22] = 3'b010;
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        rst = 1'b1; valid = 1'b0; ack = 1'b0;
        instr = 32'h0; psr = 4'h0;
        repeat (3) @(negedge clk);
        check_idle("reset", 1'b0);
        rst = 1'b0;
        #1;
        check_idle("post_reset", 1'b1);

        run_instr(fmt3(2'b10, 6'b010000), 4'h0, 0, "addcc");
        run_instr(fmt3(2'b10, 6'b000000), 4'h0, 0, "add");
        run_instr(bicc(4'b0001), 4'b0100, 0, "be_taken");
        run_instr(bicc(4'b0001), 4'b0000, 0, "be_not");

        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 16; f++)
                run_instr(bicc(4'(c)), 4'(f), 0, "sweep");

        run_instr(fmt3(2'b11, 6'b000000), 4'h0, 3, "load_ack3");
        run_instr(fmt3(2'b11, 6'b000100), 4'h0, 1, "store_ack1");
        run_instr(fmt3(2'b11, 6'b000000), 4'h0, 15, "load_ack15");
        run_instr(fmt3(2'b11, 6'b000100), 4'h0, 0, "store_timeout");
        run_instr({2'b01, 30'($urandom)}, 4'h0, 0, "call");

        // Reset landing mid-MEM with the request raised.
        instr = fmt3(2'b11, 6'b000000);
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("midmem.memreq_before", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midmem.memreq", 32'(mem_req), 32'd0);
        check("midmem.ready", 32'(ready), 32'd0);
        check("midmem.timeout", 32'(timeout), 32'd0);
        check("midmem.illegal", 32'(illegal), 32'd0);
        exp_illegal = 1'b0;
        exp_timeout = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midmem.ready_after", 32'(ready), 32'd1);

        run_instr(fmt3(2'b10, 6'b111111), 4'h0, 0, "illegal");
        run_instr(fmt3(2'b10, 6'b010101), 4'hA, 0, "after_illegal_alu");
        run_instr(bicc(4'b1000), 4'h0, 0, "after_illegal_ba");
        run_instr(fmt3(2'b00, 6'b100000), 4'h0, 0, "illegal_op2");

        for (int i = 0; i < 80; i++) begin
            w = $urandom;
            if (w[31:30] == 2'b00 && w[0]) w[24:22] = 3'b010;
            run_instr(w, 4'($urandom), int'($urandom_range(0, 17)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
